// File: rtl/interface_in.sv
// interface_in: realigns 24-lane AXI-Stream packets so the first valid lane lands on output lane 0.
// Optional feature: define INTERFACE_IN_ERR_EN to add a sticky err output for illegal sideband values and dropped empty packets.
module interface_in (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1535:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tlast,
    input  logic [5:0]    s_first,
    input  logic [5:0]    s_last_lanes,
    output logic [1535:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [23:0]   m_tkeep,
    output logic          m_tlast
`ifdef INTERFACE_IN_ERR_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [1535:0] held_q, held_d;
    logic [1535:0] data_q, data_d;
    logic [4:0]    first_q, first_d;
    logic [4:0]    last_q, last_d;
    logic [23:0]   keep_q, keep_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;
    logic [4:0]    first_n, last_n;
    logic          ll_bad, out_free, accept;
    logic [1535:0] combined;

    // Low n bits set; n = 24 wraps to all ones.
    function automatic logic [23:0] lane_mask(input logic [4:0] n);
        return 24'((25'd1 << n) - 25'd1);
    endfunction

    assign first_n  = (s_first > 6'd23) ? 5'd0 : s_first[4:0];
    assign ll_bad   = (s_last_lanes == 6'd0) | (s_last_lanes > 6'd24);
    assign last_n   = ll_bad ? 5'd24 : s_last_lanes[4:0];
    assign out_free = ~tvalid_q | m_tready;
    assign s_tready = rst_n & out_free & (state_q != FLUSH);
    assign accept   = s_tvalid & s_tready;
    assign combined = (held_q >> {first_q, 6'b0}) | (s_tdata << {5'(5'd24 - first_q), 6'b0});

    assign m_tdata  = data_q;
    assign m_tkeep  = keep_q;
    assign m_tlast  = tlast_q;
    assign m_tvalid = tvalid_q;

    // Next-state and output-register load decisions; FLUSH owns the output slot until it drains.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        first_d  = first_q;
        last_d   = last_q;
        data_d   = data_q;
        keep_d   = keep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q & ~m_tready;
        if (state_q == FLUSH) begin
            if (out_free) begin
                tvalid_d = 1'b1;
                data_d   = held_q >> {first_q, 6'b0};
                keep_d   = lane_mask(last_q - first_q);
                tlast_d  = 1'b1;
                state_d  = IDLE;
            end
        end else if (accept) begin
            if (state_q == IDLE) begin
                if (!s_tlast) begin
                    held_d  = s_tdata;
                    first_d = first_n;
                    state_d = HOLD;
                end else if (last_n > first_n) begin
                    tvalid_d = 1'b1;
                    data_d   = s_tdata >> {first_n, 6'b0};
                    keep_d   = lane_mask(last_n - first_n);
                    tlast_d  = 1'b1;
                end
            end else begin
                tvalid_d = 1'b1;
                data_d   = combined;
                held_d   = s_tdata;
                last_d   = last_n;
                tlast_d  = s_tlast & (last_n <= first_q);
                keep_d   = tlast_d ? lane_mask(5'd24 - first_q + last_n) : 24'hffffff;
                state_d  = !s_tlast ? HOLD : (last_n <= first_q) ? IDLE : FLUSH;
            end
        end
    end

    // State, held beat and registered output stage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            held_q   <= '0;
            first_q  <= '0;
            last_q   <= '0;
            data_q   <= '0;
            keep_q   <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            first_q  <= first_d;
            last_q   <= last_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

`ifdef INTERFACE_IN_ERR_EN
    logic err_q, bad;

    assign bad = accept & (((state_q == IDLE) & ((s_first > 6'd23) | (s_tlast & (ll_bad | (last_n <= first_n)))))
                         | ((state_q == HOLD) & s_tlast & ll_bad));
    assign err = err_q;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | bad;
    end
`endif

endmodule

// File: doc/interface_in.md
INTERFACE_IN -- requirements
Module: interface_in

Interface
REQ-001 SHALL have clk input 1 bit: single clock; all logic samples on its rising edge.
REQ-002 SHALL have rst_n input 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have s_tdata input 1536 bits: 24 lanes x 64 bits, lane i = bits [64i+63:64i].
REQ-004 SHALL have s_tvalid input 1 bit and s_tready output 1 bit: AXI-Stream input handshake.
REQ-005 SHALL have s_tlast input 1 bit: marks the last input beat of a packet.
REQ-006 SHALL have s_first input 6 bits: index of the first valid lane of the packet, sampled on the first beat.
REQ-007 SHALL have s_last_lanes input 6 bits: valid lane count (1..24) of the last beat, sampled on the beat with s_tlast.
REQ-008 SHALL have m_tdata output 1536 bits, m_tvalid output 1 bit and m_tready input 1 bit: lane-aligned output stream.
REQ-009 SHALL have m_tkeep output 24 bits: per-lane valid mask.
REQ-010 SHALL have m_tlast output 1 bit: marks the last output beat of a packet.

Function
REQ-011 SHALL realign packets so that output lane 0 of output beat j equals input lane (s_first + 24j) of the packet's lane sequence.
REQ-012 SHALL define N = 24*(beats-1) + s_last_lanes - s_first and emit ceil(N/24) output beats per packet.
REQ-013 SHALL use states IDLE (no held beat), HOLD (one input beat held mid-packet) and FLUSH (residual lanes pending).
REQ-014 SHALL, in IDLE on an accepted non-last beat: store the beat and the sampled s_first, emit nothing, and go to HOLD.
REQ-015 SHALL, in HOLD on an accepted beat: emit (held >> 64*first) | (current << 64*(24-first)), store the current beat and stay in HOLD; first=0 emits held unchanged.
REQ-016 SHALL, in HOLD on an accepted last beat with s_last_lanes <= first: emit the combined beat with m_tlast=1 and m_tkeep = (24-first+s_last_lanes) low bits set, then go to IDLE.
REQ-017 SHALL, in HOLD on an accepted last beat with s_last_lanes > first: emit the combined beat with m_tkeep=24'hffffff and m_tlast=0, then go to FLUSH.
REQ-018 SHALL, in FLUSH: load current >> 64*first into the output with m_tlast=1 and m_tkeep = (s_last_lanes-first) low bits set once the output register is free, then go to IDLE.
REQ-019 SHALL, in IDLE on an accepted single-beat packet (s_tlast=1) with s_last_lanes > s_first: emit s_tdata >> 64*s_first with m_tlast=1 and m_tkeep = (s_last_lanes-s_first) low bits set.
REQ-020 SHALL drop a single-beat packet with s_last_lanes <= s_first (N=0) and emit no output beat.
REQ-021 SHALL set m_tkeep=24'hffffff and m_tlast=0 on every non-final output beat.
REQ-022 SHALL register m_tdata, m_tkeep and m_tlast; they SHALL be loaded when (~m_tvalid | m_tready) and held stable while m_tvalid & ~m_tready.
REQ-023 SHALL set m_tvalid on any load and clear it on m_tready when nothing new is loaded.
REQ-024 SHALL drive s_tready = rst_n & (~m_tvalid | m_tready) & (state != FLUSH).
REQ-025 SHALL produce an output beat one cycle after the input beat that completes it (cycle after acceptance).
REQ-026 SHALL treat s_first > 23 as 0, and s_last_lanes = 0 or > 24 as 24.
REQ-027 SHALL accept back-to-back packets: the first beat of the next packet can be accepted in the cycle that returns the FSM to IDLE.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set state=IDLE, m_tvalid=0, m_tlast=0, m_tkeep=24'h0, m_tdata=0, and clear the held beat; s_tready SHALL be 0 while rst_n=0.
REQ-029 SHALL discard any partial packet or pending FLUSH when reset is asserted mid-operation; no residual beat is emitted after reset is released.

Configuration
REQ-030 SHALL, with INTERFACE_IN_ERR_EN defined, add an output err (1 bit, reset 0, sticky until reset) set the cycle after accepting a beat with s_first>23, an illegal s_last_lanes, or an N=0 drop; without the macro, err is absent and REQ-026/REQ-020 handling is silent.

Verification
REQ-031 SHALL test a single beat with first=0, last_lanes=24 -> one beat equal to input, keep=ffffff, tlast=1.
REQ-032 SHALL test 2 beats with first=5, last_lanes=3 -> one beat with lanes B0[5..23],B1[0..2], keep=0x3fffff, tlast=1.
REQ-033 SHALL test 2 beats with first=5, last_lanes=20 -> beat1 full, keep=ffffff, tlast=0; FLUSH beat of B1[5..19] with keep=0x7fff, tlast=1; s_tready=0 during FLUSH.
REQ-034 SHALL test m_tready held low for 4 cycles mid-packet -> m_tdata/keep/last stable, s_tready=0, no data loss, correct order after release.
REQ-035 SHALL test a single beat with first=10, last_lanes=10 -> no output; err=1 only when INTERFACE_IN_ERR_EN is defined.
REQ-036 SHALL test rst_n=0 for one cycle while in FLUSH -> m_tvalid=0 and m_tkeep=0 the next cycle; the next packet aligns correctly.
